dmem_arbiter: RTL and testbench

// - Shares one single-port data RAM between the IF stage (read-only fetch port) and the MEM stage (load/store port).
// - Sits between the pipeline stages and the RAM macro.
// - Issues per-cycle grants and tracks the in-flight access. Routes read data back with 1-cycle latency.
// - Drives stall_if / stall_mem to the hazard logic.
// - MEM has priority. A starvation counter guarantees IF forward progress.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_starve_ctr.sv | 38 +++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_AW         = 5;
    localparam int unsigned DMEM_DW         = 32;
    localparam int unsigned DMEM_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IF  = 2'd1,
        RD_MEM = 2'd2,
        WR_MEM = 2'd3
    } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the IF port was denied.
module dmem_arb_starve_ctr #(
    parameter int unsigned MAX = 4,
    parameter int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          sat_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat_o = (cnt_q == CW'(MAX));
    assign cnt_o = cnt_q;

    // Clear dominates; increment holds at MAX once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port data RAM between the IF fetch port and the MEM
// load/store port; MEM has priority, a starvation counter forces IF through.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = DMEM_AW,
    parameter int unsigned DW         = DMEM_DW,
    parameter int unsigned STARVE_MAX = DMEM_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_rvalid,
    output logic [DW-1:0] mem_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    dmem_arb_state_t state_q;
    dmem_arb_state_t state_d;
    logic [CW-1:0]   starve_cnt;
    logic            starve_sat;
    logic            force_if;

    dmem_arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .CW  (CW)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!if_req || if_gnt),
        .inc_i (if_req && !if_gnt),
        .cnt_o (starve_cnt),
        .sat_o (starve_sat)
    );

    // Grants are gated by rst_n so nothing reaches the RAM while in reset.
    always_comb begin
        force_if  = if_req & starve_sat;
        mem_gnt   = rst_n & mem_req & ~force_if;
        if_gnt    = rst_n & if_req & (force_if | ~mem_req);
        stall_if  = rst_n & if_req & ~if_gnt;
        stall_mem = rst_n & mem_req & ~mem_gnt;
    end

    always_comb begin
        ram_en    = if_gnt | mem_gnt;
        ram_we    = mem_gnt & mem_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (mem_gnt) begin
            ram_addr = mem_addr;
        end else if (if_gnt) begin
            ram_addr = if_addr;
        end
        if (ram_we) begin
            ram_wdata = mem_wdata;
        end
    end

    // In-flight access is whatever was granted this cycle.
    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = RD_IF;
        end else if (mem_gnt) begin
            state_d = mem_we ? WR_MEM : RD_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        if_rvalid  = (state_q == RD_IF);
        mem_rvalid = (state_q == RD_MEM);
        if_rdata   = if_rvalid ? ram_rdata : '0;
        mem_rdata  = mem_rvalid ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a reference model checked every cycle.
module tb_dmem_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [4:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        stall_if;
    logic        stall_mem;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(
        .AW         (5),
        .DW         (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // RAM macro: word i initially holds i; read data is junk unless a read happened.
    logic [31:0] ram_mem [32];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= 32'(i);
            ram_init  <= 1'b1;
            ram_rdata <= $urandom;
        end else if (ram_en && !ram_we) begin
            ram_rdata <= ram_mem[ram_addr];
        end else begin
            if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= $urandom;
        end
    end

    // Reference model: MEM wins unless IF has waited STARVE_MAX cycles;
    // a read granted now returns the word's current contents one cycle later.
    logic [31:0] shadow [32];
    bit          shadow_init = 1'b0;
    int          m_starve = 0;
    int          m_pend = 0;          // 0 none, 1 IF read, 2 MEM read
    logic [31:0] m_pend_data = '0;
    logic        e_ig, e_mg, e_en, e_we, e_iv, e_mv, e_si, e_sm;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata, e_ird, e_mrd;
    logic        starved;

    always @(negedge clk) begin
        if (!shadow_init) begin
            for (int i = 0; i < 32; i++) shadow[i] = 32'(i);
            shadow_init = 1'b1;
        end
        if (!rst_n) begin
            {e_ig, e_mg, e_en, e_we, e_iv, e_mv, e_si, e_sm} = '0;
            e_addr = '0; e_wdata = '0; e_ird = '0; e_mrd = '0;
            m_starve = 0;
            m_pend   = 0;
        end else begin
            starved = if_req && (m_starve == STARVE_MAX);
            e_mg    = mem_req && !starved;
            e_ig    = if_req && !e_mg;
            e_en    = e_ig || e_mg;
            e_we    = e_mg && mem_we;
            e_addr  = e_mg ? mem_addr : (e_ig ? if_addr : 5'd0);
            e_wdata = e_we ? mem_wdata : 32'd0;
            e_iv    = (m_pend == 1);
            e_mv    = (m_pend == 2);
            e_ird   = e_iv ? m_pend_data : 32'd0;
            e_mrd   = e_mv ? m_pend_data : 32'd0;
            e_si    = if_req && !e_ig;
            e_sm    = mem_req && !e_mg;
        end
        chk("if_gnt", 32'(if_gnt), 32'(e_ig));
        chk("mem_gnt", 32'(mem_gnt), 32'(e_mg));
        chk("ram_en", 32'(ram_en), 32'(e_en));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wdata", ram_wdata, e_wdata);
        chk("if_rvalid", 32'(if_rvalid), 32'(e_iv));
        chk("mem_rvalid", 32'(mem_rvalid), 32'(e_mv));
        chk("if_rdata", if_rdata, e_ird);
        chk("mem_rdata", mem_rdata, e_mrd);
        chk("stall_if", 32'(stall_if), 32'(e_si));
        chk("stall_mem", 32'(stall_mem), 32'(e_sm));
        if (rst_n) begin
            if (e_ig) begin
                m_pend = 1; m_pend_data = shadow[if_addr];
            end else if (e_mg && !mem_we) begin
                m_pend = 2; m_pend_data = shadow[mem_addr];
            end else begin
                m_pend = 0;
            end
            if (e_we) shadow[mem_addr] = mem_wdata;
            if (!if_req || e_ig) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [4:0] ia, input logic mr,
                         input logic mw, input logic [4:0] ma, input logic [31:0] md);
        if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
    endtask

    initial begin
        // Reset with both requesting: nothing may be granted.
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'd0);
        @(negedge clk);
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_mem_gnt", 32'(mem_gnt), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_rvalid", 32'({if_rvalid, mem_rvalid}), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_mem_gnt", 32'(mem_gnt), 32'd1);
        chk("rel_if_gnt", 32'(if_gnt), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("rel_mem_rdata", mem_rdata, 32'd2);
        next_cycle();

        // IF alone, address 3.
        drive(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("if_gnt_n", 32'(if_gnt), 32'd1);
        chk("if_stall_n", 32'(stall_if), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("if_rvalid_n1", 32'(if_rvalid), 32'd1);
        chk("if_rdata_n1", if_rdata, 32'h3);
        chk("if_stall_n1", 32'(stall_if), 32'd0);
        next_cycle();

        // Both requesting continuously: IF forced through every fifth cycle.
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, 5'(c + 8), 1'b1, 1'b0, 5'(c), 32'd0);
            @(negedge clk);
            chk("rr_if_gnt", 32'(if_gnt), 32'((c % 5) == 4));
            chk("rr_mem_gnt", 32'(mem_gnt), 32'((c % 5) != 4));
            if (c == 4) chk("rr_stall_mem", 32'(stall_mem), 32'd1);
            next_cycle();
        end

        // Store then load of the same word.
        drive(1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_ram_we", 32'(ram_we), 32'd1);
        chk("st_ram_wdata", ram_wdata, 32'hDEADBEEF);
        next_cycle();
        drive(1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 32'd0);
        @(negedge clk);
        chk("ld_ram_we", 32'(ram_we), 32'd0);
        chk("st_no_rvalid", 32'(mem_rvalid), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("ld_mem_rvalid", 32'(mem_rvalid), 32'd1);
        chk("ld_mem_rdata", mem_rdata, 32'hDEADBEEF);
        next_cycle();

        // Reset pulse right after a load grant discards the response.
        drive(1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 32'd0);
        @(negedge clk);
        chk("mr_mem_gnt", 32'(mem_gnt), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("mr_rvalid_rst", 32'(mem_rvalid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rvalid_rel", 32'(mem_rvalid), 32'd0);
        next_cycle();

        // Starve IF to 3, drop it once, then 4 more denials before the grant.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 32'd0);
            @(negedge clk);
            chk("sv_pre_if_gnt", 32'(if_gnt), 32'd0);
            next_cycle();
        end
        drive(1'b0, 5'd9, 1'b1, 1'b0, 5'd1, 32'd0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 5'(c + 20), 1'b1, 1'b0, 5'd1, 32'd0);
            @(negedge clk);
            chk("sv_if_gnt", 32'(if_gnt), 32'(c == 4));
            next_cycle();
        end

        // Mixed traffic checked by the model only.
        for (int c = 0; c < 60; c++) begin
            drive(1'($urandom_range(1)), 5'($urandom_range(31)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            next_cycle();
        end
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        next_cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
